alarm_chaser: RTL and testbench

ALARM_CHASER -- requirements
Module: alarm_chaser

---
 rtl/alarm_chaser.sv | 202 ++++++++++++++++++++
 tb/tb_alarm_chaser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_chaser.sv
// alarm_chaser: light-chaser alarm driver with four patterns,
// a programmable step period and a sweep repeat count.
module alarm_chaser #(
  parameter int N_LIGHTS = 24,
  parameter int DIV_W    = 16,
  parameter int REP_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SW,
  input  logic                sign,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    div,
  input  logic [REP_W-1:0]    reps,
  output logic [N_LIGHTS-1:0] light,
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam logic [PW-1:0] LAST = PW'(N_LIGHTS - 1);

  localparam logic [1:0] M_SWEEP  = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_FILL   = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [N_LIGHTS-1:0] light_d;
  logic               busy_d, done_d;

  logic [PW-1:0]      step_pos;
  logic               step_dir;
  logic               wrap;
  logic [REP_W-1:0]   cnt_inc;

  function automatic logic [N_LIGHTS-1:0] pattern(
    input logic [1:0]    m,
    input logic [PW-1:0] p
  );
    logic [N_LIGHTS-1:0] ones;
    logic [N_LIGHTS-1:0] one;
    logic [PW-1:0]       sh;
    ones = '1;
    one  = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    sh   = LAST - p;
    case (m)
      M_FILL:  pattern = ones << sh;
      M_BLINK: pattern = (p == '0) ? ones : '0;
      default: pattern = one << sh;
    endcase
  endfunction

  // Position the chaser moves to on the next tick, and whether
  // that tick closes a sweep. In BOUNCE the return to pos 0 is
  // shown for a full step before the sweep is counted.
  always_comb begin
    step_pos = pos_q + 1'b1;
    step_dir = dir_q;
    wrap     = 1'b0;
    case (mode_q)
      M_SWEEP, M_FILL: begin
        if (pos_q == LAST) begin
          step_pos = '0;
          wrap     = 1'b1;
        end
      end
      M_BOUNCE: begin
        if (!dir_q) begin
          if (pos_q == LAST) begin
            step_pos = LAST - 1'b1;
            step_dir = 1'b1;
          end
        end else if (pos_q == '0) begin
          step_pos = PW'(1);
          step_dir = 1'b0;
          wrap     = 1'b1;
        end else begin
          step_pos = pos_q - 1'b1;
        end
      end
      default: begin
        step_pos = (pos_q == '0) ? PW'(1) : '0;
        wrap     = (pos_q != '0);
      end
    endcase
  end

  // Next-state and registered-output logic for IDLE/RUN/HOLD.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    div_d   = div_q;
    reps_d  = reps_q;
    light_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        pos_d = '0;
        dir_d = 1'b0;
        pre_d = '0;
        cnt_d = '0;
        if (SW && sign) begin
          state_d = RUN;
          mode_d  = mode;
          div_d   = div;
          reps_d  = reps;
          busy_d  = 1'b1;
          light_d = pattern(mode, '0);
        end
      end
      RUN: begin
        if (!SW || !sign) begin
          state_d = IDLE;
          pos_d   = '0;
          dir_d   = 1'b0;
          pre_d   = '0;
          cnt_d   = '0;
        end else begin
          busy_d  = 1'b1;
          light_d = light;
          if (pre_q == div_q) begin
            pre_d   = '0;
            pos_d   = step_pos;
            dir_d   = step_dir;
            light_d = pattern(mode_q, step_pos);
            if (wrap && reps_q != '0) begin
              cnt_d = cnt_inc;
              if (cnt_inc == reps_q) begin
                state_d = HOLD;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                light_d = '0;
              end
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (!SW || !sign) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
        dir_d   = 1'b0;
        pre_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      div_q   <= '0;
      reps_q  <= '0;
      light   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      reps_q  <= reps_d;
      light   <= light_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_alarm_chaser.sv
// tb_alarm_chaser: scenario tasks checked against a pattern-list
// model of the chaser (N_LIGHTS=8).
module tb_alarm_chaser;

  logic        clk;
  logic        rst;
  logic        SW;
  logic        sign;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [3:0]  reps;
  logic [7:0]  light;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0] light;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  obs_t got[$];
  int   assertions = 0;
  int   failures   = 0;

  alarm_chaser #(.N_LIGHTS(8), .DIV_W(16), .REP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .SW    (SW),
    .sign  (sign),
    .mode  (mode),
    .div   (div),
    .reps  (reps),
    .light (light),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: list the patterns of each sweep, hold each for d+1
  // cycles, then a done cycle and one quiet HOLD cycle.
  task automatic build(input int m, input int d, input int r,
                       input int sweeps);
    logic [7:0] msb;
    logic [7:0] ones;
    logic [7:0] seq[$];
    msb  = 8'h80;
    ones = 8'hFF;
    exp_q.delete();
    for (int s = 0; s < sweeps; s++) begin
      seq.delete();
      case (m)
        0: for (int i = 0; i < 8; i++) seq.push_back(msb >> i);
        1: begin
          for (int i = (s == 0) ? 0 : 1; i < 8; i++)
            seq.push_back(msb >> i);
          for (int i = 6; i >= 0; i--) seq.push_back(msb >> i);
        end
        2: for (int i = 0; i < 8; i++) seq.push_back(ones << (7 - i));
        default: begin
          seq.push_back(ones);
          seq.push_back(8'h00);
        end
      endcase
      foreach (seq[k])
        for (int c = 0; c <= d; c++)
          exp_q.push_back('{light: seq[k], busy: 1'b1, done: 1'b0});
    end
    if (r != 0) begin
      exp_q.push_back('{light: 8'h00, busy: 1'b0, done: 1'b1});
      exp_q.push_back('{light: 8'h00, busy: 1'b0, done: 1'b0});
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      got.push_back('{light: light, busy: busy, done: done});
    end
  endtask

  task automatic start(input int m, input int d, input int r);
    @(negedge clk);
    mode = 2'(m);
    div  = 16'(d);
    reps = 4'(r);
    SW   = 1'b1;
    sign = 1'b1;
    got.delete();
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{light: 8'h00, busy: 1'b0, done: 1'b0});
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    SW   = 1'b0;
    sign = 1'b0;
    mode = 2'd0;
    div  = 16'd0;
    reps = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    assertions++;
    if ({light, busy, done} !== 10'd0) begin
      failures++;
      $display("FAIL reset: light=%h busy=%b done=%b want 00 0 0",
               light, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    add_idle(3);
    capture(3);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mode(input string name, input int m,
                           input int d, input int r,
                           input int sweeps, input int linger);
    start(m, d, r);
    build(m, d, r, sweeps);
    add_idle(linger);
    capture(exp_q.size());
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s[%0d]: light=%h busy=%b done=%b want light=%h busy=%b done=%b",
                 name, i, got[i].light, got[i].busy, got[i].done,
                 exp_q[i].light, exp_q[i].busy, exp_q[i].done);
      end
    end
    sign = 1'b0;
    got.delete();
    exp_q.delete();
    add_idle(2);
    capture(2);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_release[%0d]: got %h want %h",
                 name, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_blink_unlimited;
    start(3, 3, 0);
    build(3, 3, 0, 13);
    capture(50);
    mode = 2'd0;
    div  = 16'd0;
    reps = 4'd1;
    capture(50);
    for (int i = 0; i < 100; i++) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL blink[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
    sign = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort;
    start(0, 0, 0);
    build(0, 0, 0, 1);
    capture(4);
    sign = 1'b0;
    capture(3);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    add_idle(3);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_sign[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
    start(1, 0, 0);
    build(1, 0, 0, 1);
    capture(5);
    SW = 1'b0;
    capture(2);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    add_idle(2);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_sw[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
    start(0, 0, 1);
    build(0, 0, 1, 1);
    capture(8);
    sign = 1'b0;
    capture(2);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    add_idle(2);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL abort_final[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    start(2, 0, 0);
    capture(3);
    #2;
    rst = 1'b1;
    #1;
    assertions++;
    if ({light, busy, done} !== 10'd0) begin
      failures++;
      $display("FAIL async_rst: light=%h busy=%b done=%b want 00 0 0",
               light, busy, done);
    end
    sign = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    add_idle(3);
    capture(3);
    foreach (exp_q[i]) begin
      assertions++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL post_rst_idle[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    int m;
    int d;
    int r;
    for (int it = 0; it < 8; it++) begin
      m = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 2));
      r = int'($urandom_range(1, 3));
      test_mode("rand", m, d, r, r, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_mode("sweep", 0, 0, 1, 1, 0);
    test_mode("bounce", 1, 1, 1, 1, 0);
    test_mode("fill", 2, 0, 2, 2, 4);
    test_mode("bounce2", 1, 0, 2, 2, 1);
    test_mode("blink1", 3, 2, 1, 1, 2);
    test_blink_unlimited();
    test_abort();
    test_async_reset();
    test_mode("after_rst", 0, 0, 1, 1, 0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
